// File: rtl/audio_sample_fifo_pkg.sv
// Shared types and defaults for the audio sample rate-adapting FIFO.
// Holds the stereo entry layout, playback states and small helpers.
package audio_sample_fifo_pkg;

  localparam int unsigned PCM_W               = 16;
  localparam int unsigned DEFAULT_CLK_FREQ    = 25_000_000;
  localparam int unsigned DEFAULT_SAMPLE_FREQ = 44_100;

  typedef struct packed {
    logic [PCM_W-1:0] l;
    logic [PCM_W-1:0] r;
  } stereo_t;

  typedef enum logic {
    ST_FILLING = 1'b0,
    ST_PLAYING = 1'b1
  } play_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/audio_fifo_sync.sv
// Generic single-clock FIFO with registered read data and occupancy output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module audio_fifo_sync #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] FULL_XOR = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH_LOG2:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2:0] rptr_q, rptr_d;
  logic [WIDTH-1:0]    rd_data_q, rd_data_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    rd_data_d = rd_data_q;
    if (wr_en) wptr_d = wptr_q + PTR_ONE;
    // Read data is registered: a pop presents the entry on the following cycle.
    if (rd_en) begin
      rptr_d    = rptr_q + PTR_ONE;
      rd_data_d = mem_q[rptr_q[DEPTH_LOG2-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      rd_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= wr_data;
  end

  assign rd_data = rd_data_q;
  assign full    = (wptr_q ^ rptr_q) == FULL_XOR;
  assign empty   = (wptr_q == rptr_q);
  assign level   = wptr_q - rptr_q;

endmodule

// File: rtl/audio_sample_fifo.sv
// Rate-adapts bursty stereo PCM to a steady SAMPLE_FREQ stream using a
// fractional tick generator, a prefill/underrun FSM and a small FIFO.
module audio_sample_fifo
  import audio_sample_fifo_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = DEFAULT_CLK_FREQ,
  parameter int unsigned SAMPLE_FREQ = DEFAULT_SAMPLE_FREQ,
  parameter int          DEPTH_LOG2  = 3,
  parameter int          PREFILL     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           in_l,
  input  logic [15:0]           in_r,
  input  logic                  in_valid,
  output logic [15:0]           out_l,
  output logic [15:0]           out_r,
  output logic                  out_valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  playing,
  output logic [7:0]            underrun_count,
  output logic [7:0]            overflow_count
);

  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);
  localparam logic [32:0]   SF_33     = 33'(SAMPLE_FREQ);
  localparam logic [32:0]   CF_33     = 33'(CLK_FREQ);

  logic [31:0]  acc_q, acc_d;
  logic [32:0]  sum;
  logic         tick;
  play_state_e  state_q, state_d;
  logic [7:0]   underrun_q, underrun_d;
  logic [7:0]   overflow_q, overflow_d;
  logic         out_valid_q, out_valid_d;

  logic         pop, push;
  logic         fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;
  stereo_t      wr_sample, rd_sample;

  assign wr_sample = '{l: in_l, r: in_r};

  // Input has no ready: in_valid is a one-cycle strobe that is either stored
  // or dropped (and counted); a same-cycle pop frees room for it when full.
  always_comb begin
    sum         = {1'b0, acc_q} + SF_33;
    tick        = (sum >= CF_33);
    acc_d       = tick ? 32'(sum - CF_33) : sum[31:0];
    pop         = (state_q == ST_PLAYING) && tick && !fifo_empty;
    push        = in_valid && (!fifo_full || pop);
    state_d     = state_q;
    underrun_d  = underrun_q;
    overflow_d  = overflow_q;
    out_valid_d = tick;
    if (in_valid && fifo_full && !pop) overflow_d = sat_inc8(overflow_q);
    case (state_q)
      ST_FILLING: if (fifo_level >= PREFILL_L) state_d = ST_PLAYING;
      ST_PLAYING: begin
        if (tick && fifo_empty) begin
          underrun_d = sat_inc8(underrun_q);
          state_d    = ST_FILLING;
        end
      end
      default: state_d = ST_FILLING;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      state_q     <= ST_FILLING;
      underrun_q  <= '0;
      overflow_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      state_q     <= state_d;
      underrun_q  <= underrun_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  // The FIFO read register doubles as the output sample register: it only
  // changes on a pop, so the output holds while filling or underrunning.
  audio_fifo_sync #(
    .WIDTH      ($bits(stereo_t)),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (wr_sample),
    .rd_en   (pop),
    .rd_data (rd_sample),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign out_l          = rd_sample.l;
  assign out_r          = rd_sample.r;
  assign out_valid      = out_valid_q;
  assign level          = fifo_level;
  assign playing        = (state_q == ST_PLAYING);
  assign underrun_count = underrun_q;
  assign overflow_count = overflow_q;

endmodule
